// File: rtl/usb_fs_rx_bitstream_if.sv
// ----------------------------------------------------------------------------
// Module  : usb_fs_rx_bitstream_if
// Purpose : Pad-side inputs and packet byte-stream outputs of the full-speed
//           USB receive front end, bundled for connection to the protocol side.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface usb_fs_rx_bitstream_if;
  logic       usb_p_rx;   // D+ pad, asynchronous to the receiver clock
  logic       usb_n_rx;   // D- pad, asynchronous to the receiver clock
  logic       rx_en;      // receive allowed (normally ~usb_tx_en)
  logic       pkt_start;  // SYNC found
  logic [7:0] rx_data;    // received byte, LSB first on the wire
  logic       rx_valid;   // one pulse per completed byte
  logic       pkt_end;    // packet terminated (good or bad)
  logic       rx_err;     // with pkt_end: packet was corrupt
  logic       usb_reset;  // long SE0 in progress

  // Drives the pads and consumes the decoded stream
  modport master (
    output usb_p_rx, usb_n_rx, rx_en,
    input  pkt_start, rx_data, rx_valid, pkt_end, rx_err, usb_reset
  );

  // The receiver itself
  modport slave (
    input  usb_p_rx, usb_n_rx, rx_en,
    output pkt_start, rx_data, rx_valid, pkt_end, rx_err, usb_reset
  );
endinterface

`default_nettype wire

// File: rtl/usb_fs_rx_bitstream.sv
// ----------------------------------------------------------------------------
// Module  : usb_fs_rx_bitstream
// Purpose : Full-speed USB receive front end. Synchronizes the D+/D- pads,
//           recovers the 12 Mb/s bit clock from 4x oversampling at 48 MHz,
//           detects SYNC/EOP, NRZI-decodes, removes stuff bits and assembles
//           bytes LSB first. Also flags bus reset (long SE0).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module usb_fs_rx_bitstream #(
  parameter int RESET_CYCLES = 120
) (
  input  wire logic              clk_48mhz,
  input  wire logic              reset_n,
  usb_fs_rx_bitstream_if.slave   bus
);

  // Line symbols as {D+, D-}
  localparam logic [1:0] c_SYM_SE0 = 2'b00;
  localparam logic [1:0] c_SYM_K   = 2'b01;
  localparam logic [1:0] c_SYM_J   = 2'b10;
  localparam logic [1:0] c_SYM_SE1 = 2'b11;

  // Last six sampled symbols of a SYNC field, oldest first
  localparam logic [11:0] c_SYNC_WIN = {c_SYM_K, c_SYM_J, c_SYM_K, c_SYM_J, c_SYM_K, c_SYM_K};

  localparam int                 c_CNT_W   = $clog2(RESET_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RESET_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_DATA  = 3'd2,
    S_EOP   = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  // Pad synchronizers (reset to idle J so no false SE0 after reset)
  logic r_p_meta, r_p_sync, r_n_meta, r_n_sync;

  // Bit clock recovery
  logic [1:0] r_line_prev;
  logic [1:0] r_phase;
  logic [9:0] r_hist;

  // Receive FSM
  state_t     r_state;
  logic [1:0] r_nrzi_prev;
  logic [2:0] r_ones;
  logic [2:0] r_bitcnt;
  logic [6:0] r_shift;
  logic       r_pkt_start;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_pkt_end;
  logic       r_rx_err;

  // Bus reset detector
  logic [c_CNT_W-1:0] r_se0_cnt;
  logic               r_usb_reset;

  logic [1:0]  w_sym;
  logic [1:0]  w_phase;
  logic        w_sample;
  logic [11:0] w_hist_next;
  logic        w_sync_hit;
  logic        w_bit;
  logic [7:0]  w_shift_next;

  assign w_sym        = {r_p_sync, r_n_sync};
  // A symbol change realigns the phase; the bit centre is two clocks later
  assign w_phase      = (w_sym != r_line_prev) ? 2'd0 : r_phase + 2'd1;
  assign w_sample     = (w_phase == 2'd2);
  assign w_hist_next  = {r_hist, w_sym};
  assign w_sync_hit   = (w_hist_next == c_SYNC_WIN);
  // NRZI: no transition is a 1
  assign w_bit        = (w_sym == r_nrzi_prev);
  assign w_shift_next = {w_bit, r_shift};

  // Two-flop synchronizer on each pad
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_p_meta <= 1'b1;
      r_p_sync <= 1'b1;
      r_n_meta <= 1'b0;
      r_n_sync <= 1'b0;
    end else begin
      r_p_meta <= bus.usb_p_rx;
      r_p_sync <= r_p_meta;
      r_n_meta <= bus.usb_n_rx;
      r_n_sync <= r_n_meta;
    end
  end

  // Phase counter and history of sampled symbols for SYNC matching
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_line_prev <= c_SYM_J;
      r_phase     <= 2'd0;
      r_hist      <= '0;
    end else begin
      r_line_prev <= w_sym;
      r_phase     <= w_phase;
      if (w_sample) begin
        r_hist <= w_hist_next[9:0];
      end
    end
  end

  // Saturating count of consecutive SE0 clocks, independent of the FSM
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_se0_cnt   <= '0;
      r_usb_reset <= 1'b0;
    end else if (w_sym == c_SYM_SE0) begin
      if (r_se0_cnt != c_CNT_MAX) begin
        r_se0_cnt <= r_se0_cnt + 1'b1;
      end
      r_usb_reset <= (r_se0_cnt >= c_CNT_MAX - 1'b1);
    end else begin
      r_se0_cnt   <= '0;
      r_usb_reset <= 1'b0;
    end
  end

  // Packet FSM: SYNC hunt, NRZI decode, unstuffing, byte assembly, EOP
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_nrzi_prev <= c_SYM_J;
      r_ones      <= 3'd0;
      r_bitcnt    <= 3'd0;
      r_shift     <= 7'd0;
      r_pkt_start <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_pkt_end   <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      r_pkt_start <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_pkt_end   <= 1'b0;
      r_rx_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.rx_en && w_sample && (w_sym == c_SYM_K)) begin
            r_state <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (!bus.rx_en) begin
            r_state <= S_IDLE;
          end else if (w_sample) begin
            if (w_sync_hit) begin
              r_pkt_start <= 1'b1;
              r_nrzi_prev <= c_SYM_K;
              r_ones      <= 3'd0;
              r_bitcnt    <= 3'd0;
              r_state     <= S_DATA;
            end else if ((w_sym == c_SYM_SE0) || (w_sym == c_SYM_SE1)) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (!bus.rx_en) begin
            // Our own transmitter took the bus: drop silently
            r_state <= S_ABORT;
          end else if (w_sample) begin
            case (w_sym)
              c_SYM_J, c_SYM_K: begin
                r_nrzi_prev <= w_sym;
                if (r_ones == 3'd6) begin
                  // Stuff slot: a 0 is discarded, a 1 is a violation
                  if (w_bit) begin
                    r_pkt_end <= 1'b1;
                    r_rx_err  <= 1'b1;
                    r_state   <= S_ABORT;
                  end else begin
                    r_ones <= 3'd0;
                  end
                end else begin
                  r_ones   <= w_bit ? r_ones + 3'd1 : 3'd0;
                  r_shift  <= w_shift_next[7:1];
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
                    r_rx_data  <= w_shift_next;
                    r_rx_valid <= 1'b1;
                  end
                end
              end
              c_SYM_SE0: begin
                // A partial byte is dropped and marks the packet bad
                r_pkt_end <= 1'b1;
                r_rx_err  <= (r_bitcnt != 3'd0);
                r_state   <= S_EOP;
              end
              default: begin
                r_pkt_end <= 1'b1;
                r_rx_err  <= 1'b1;
                r_state   <= S_ABORT;
              end
            endcase
          end
        end
        S_EOP, S_ABORT: begin
          if (w_sample && (w_sym == c_SYM_J)) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pkt_start = r_pkt_start;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.pkt_end   = r_pkt_end;
  assign bus.rx_err    = r_rx_err;
  assign bus.usb_reset = r_usb_reset;

endmodule

`default_nettype wire

// File: tb/tb_usb_fs_rx_bitstream.sv
// ----------------------------------------------------------------------------
// Module  : tb_usb_fs_rx_bitstream
// Purpose : Directed bench for usb_fs_rx_bitstream. Builds NRZI/bit-stuffed
//           line traffic from byte lists and checks the decoded stream.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_usb_fs_rx_bitstream;

  localparam logic [1:0] c_J   = 2'b10;
  localparam logic [1:0] c_K   = 2'b01;
  localparam logic [1:0] c_SE0 = 2'b00;

  logic clk_48mhz = 1'b0;
  logic reset_n   = 1'b0;

  usb_fs_rx_bitstream_if bus();

  usb_fs_rx_bitstream #(.RESET_CYCLES(120)) dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  // ---------------- output monitor ----------------
  int         n_start   = 0;
  int         n_end     = 0;
  int         n_err_end = 0;
  int         n_bytes   = 0;
  int         n_coinc   = 0;
  int         n_orphan  = 0;
  logic [7:0] byte_log [0:255];

  // Record every pulse on the falling edge, away from the active edge
  always @(negedge clk_48mhz) begin
    if (bus.rx_valid) begin
      byte_log[n_bytes[7:0]] <= bus.rx_data;
      n_bytes <= n_bytes + 1;
    end
    if (bus.pkt_start) n_start <= n_start + 1;
    if (bus.pkt_end) begin
      n_end <= n_end + 1;
      if (bus.rx_err) n_err_end <= n_err_end + 1;
    end
    if (bus.rx_valid && bus.pkt_end) n_coinc <= n_coinc + 1;
    if (bus.rx_err && !bus.pkt_end) n_orphan <= n_orphan + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int b_start, b_end, b_err, b_bytes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_start = n_start;
    b_end   = n_end;
    b_err   = n_err_end;
    b_bytes = n_bytes;
  endtask

  task automatic expect_pkt(input string tag, input int s, input int nb, input int e, input int ee);
    check({tag, "_starts"}, 32'(n_start - b_start), 32'(s));
    check({tag, "_bytes"},  32'(n_bytes - b_bytes), 32'(nb));
    check({tag, "_ends"},   32'(n_end - b_end), 32'(e));
    check({tag, "_errs"},   32'(n_err_end - b_err), 32'(ee));
  endtask

  // ---------------- line transmitter ----------------
  logic       tx_bits[$];
  int         tx_ones;
  logic [1:0] tx_line = c_J;

  task automatic drive(input logic [1:0] s, input int n);
    bus.usb_p_rx = s[1];
    bus.usb_n_rx = s[0];
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic tx_clear();
    tx_bits.delete();
    tx_ones = 0;
  endtask

  task automatic tx_sync();
    repeat (7) tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
    tx_ones = 0;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      tx_bits.push_back(b[i]);
      if (b[i]) begin
        tx_ones++;
        if (tx_ones == 6) begin
          tx_bits.push_back(1'b0);
          tx_ones = 0;
        end
      end else begin
        tx_ones = 0;
      end
    end
  endtask

  // NRZI-encode bits [from, upto); jit alternates 3/5-clock bit periods
  task automatic tx_send(input bit jit, input int from, input int upto, input bit eop);
    for (int i = from; i < upto; i++) begin
      if (!tx_bits[i]) tx_line = (tx_line == c_J) ? c_K : c_J;
      drive(tx_line, jit ? (((i % 2) == 1) ? 5 : 3) : 4);
    end
    if (eop) begin
      drive(c_SE0, 8);
      tx_line = c_J;
      drive(c_J, 24);
    end
  endtask

  task automatic ack_round(input string tag, input bit jit);
    tx_clear();
    tx_sync();
    tx_byte(8'hD2);
    snap();
    tx_send(jit, 0, tx_bits.size(), 1'b1);
    expect_pkt(tag, 1, 1, 1, 0);
    check({tag, "_byte"}, 32'(byte_log[b_bytes[7:0]]), 32'h0000_00D2);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] crc;
  logic        fb;
  logic [7:0]  d0_exp [0:6];

  initial begin
    bus.usb_p_rx = 1'b1;
    bus.usb_n_rx = 1'b0;
    bus.rx_en    = 1'b1;
    repeat (3) @(posedge clk_48mhz);
    #1;
    check("reset_outputs",
          32'({bus.pkt_start, bus.rx_data, bus.rx_valid, bus.pkt_end, bus.rx_err, bus.usb_reset}),
          32'h0);
    reset_n = 1'b1;
    drive(c_J, 20);

    // 1. ACK handshake
    ack_round("ack", 1'b0);

    // 2. DATA0 with four 0xFF bytes (heavy stuffing) plus CRC16
    crc = 16'hFFFF;
    for (int k = 0; k < 32; k++) begin
      fb  = 1'b1 ^ crc[15];
      crc = {crc[14:0], 1'b0};
      if (fb) crc = crc ^ 16'h8005;
    end
    crc = ~crc;
    d0_exp[0] = 8'hC3;
    for (int k = 1; k < 5; k++) d0_exp[k] = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      d0_exp[5][i] = crc[15 - i];
      d0_exp[6][i] = crc[7 - i];
    end
    tx_clear();
    tx_sync();
    for (int k = 0; k < 7; k++) tx_byte(d0_exp[k]);
    snap();
    tx_send(1'b0, 0, tx_bits.size(), 1'b1);
    expect_pkt("data0", 1, 7, 1, 0);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("data0_byte%0d", k), 32'(byte_log[8'(b_bytes + k)]), 32'(d0_exp[k]));
    end

    // EOP after a partial byte: byte delivered, packet flagged bad
    tx_clear();
    tx_sync();
    tx_byte(8'hD2);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
    snap();
    tx_send(1'b0, 0, tx_bits.size(), 1'b1);
    expect_pkt("partial", 1, 1, 1, 1);
    check("partial_byte", 32'(byte_log[b_bytes[7:0]]), 32'h0000_00D2);

    // 3. Seven ones after SYNC: stuff violation, then re-arm
    tx_clear();
    tx_sync();
    repeat (7) tx_bits.push_back(1'b1);
    snap();
    tx_send(1'b0, 0, tx_bits.size(), 1'b1);
    expect_pkt("stuffviol", 1, 0, 1, 1);
    ack_round("rearm", 1'b0);

    // 4. Long SE0 -> bus reset
    snap();
    drive(c_SE0, 118);
    check("usb_reset_before", 32'(bus.usb_reset), 32'h0);
    drive(c_SE0, 7);
    check("usb_reset_asserted", 32'(bus.usb_reset), 32'h1);
    drive(c_J, 3);
    check("usb_reset_released", 32'(bus.usb_reset), 32'h0);
    drive(c_J, 20);
    check("usb_reset_no_pkt_end", 32'(n_end - b_end), 32'h0);

    // 5. ACK with alternating 3/5-clock bit periods
    ack_round("jitter", 1'b1);

    // 6a. rx_en dropped inside the first DATA0 byte
    tx_clear();
    tx_sync();
    for (int k = 0; k < 7; k++) tx_byte(d0_exp[k]);
    snap();
    tx_send(1'b0, 0, 13, 1'b0);
    bus.rx_en = 1'b0;
    drive(c_SE0, 8);
    tx_line = c_J;
    drive(c_J, 8);
    bus.rx_en = 1'b1;
    drive(c_J, 16);
    expect_pkt("rxen_abort", 1, 0, 0, 0);
    ack_round("after_rxen", 1'b0);

    // 6b. reset_n pulsed mid-packet (rx_data still holds 0xD2 here)
    tx_clear();
    tx_sync();
    tx_byte(8'hD2);
    tx_send(1'b0, 0, 12, 1'b0);
    #5 reset_n = 1'b0;
    #1;
    check("midreset_outputs",
          32'({bus.pkt_start, bus.rx_data, bus.rx_valid, bus.pkt_end, bus.rx_err, bus.usb_reset}),
          32'h0);
    @(posedge clk_48mhz);
    #3 reset_n = 1'b1;
    snap();
    tx_send(1'b0, 12, tx_bits.size(), 1'b1);
    expect_pkt("midreset_tail", 0, 0, 0, 0);
    ack_round("after_reset", 1'b0);

    check("valid_end_coincide", 32'(n_coinc), 32'h0);
    check("err_without_end", 32'(n_orphan), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
